// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S timing constants and receiver state encoding
package i2s_pkg;
  localparam int PERIOD = 32;
  localparam int HALF_PERIOD = 16;
  localparam int SLOT_BITS = 32;
  localparam int SAMPLE_PHASE = 23;
  localparam int CNT_W = $clog2(PERIOD);
  localparam int SLOT_W = $clog2(SLOT_BITS);
  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} i2s_rx_state;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: sck/phase/slot generator shared by the I2S receive and transmit paths
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              sck,
  output logic [CNT_W-1:0]  cnt,
  output logic [SLOT_W-1:0] slot,
  output logic              bit_end,
  output logic              sample
);
  logic              sck_q, sck_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  assign bit_end = run && cnt_q == CNT_W'(PERIOD - 1);
  assign sample  = run && cnt_q == CNT_W'(SAMPLE_PHASE);
  always_comb begin
    cnt_d  = run ? cnt_q + 1'b1 : '0;
    slot_d = !run ? '0 : bit_end ? slot_q + 1'b1 : slot_q;
    sck_d  = !run ? 1'b0 : cnt_q == CNT_W'(HALF_PERIOD - 1) ? 1'b1 : bit_end ? 1'b0 : sck_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= 1'b0;
      cnt_q  <= '0;
      slot_q <= '0;
    end else begin
      sck_q  <= sck_d;
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end
  assign sck  = sck_q;
  assign cnt  = cnt_q;
  assign slot = slot_q;
endmodule

// File: rtl/i2s_receive.sv
// i2s_receive: I2S bus master receiver producing packed {left, right} frames
module i2s_receive
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           sd,
  output logic                           sck,
  output logic                           ws,
  output logic signed [2*DATA_WIDTH-1:0] dout,
  output logic                           dout_valid,
  output logic                           busy
);
  logic [1:0]            sync_q;
  logic                  sd_s;
  i2s_rx_state           state_q, state_d;
  logic                  ws_q, ws_d, busy_q, busy_d, valid_q, valid_d;
  logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic [2*DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  run, bit_end, sample, frame_edge, take;
  logic [CNT_W-1:0]      unused_cnt;
  logic [SLOT_W-1:0]     slot;
  assign sd_s = sync_q[1];
  assign run  = state_q != IDLE;
  i2s_clk_gen u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .sck     (sck),
    .cnt     (unused_cnt),
    .slot    (slot),
    .bit_end (bit_end),
    .sample  (sample)
  );
  assign frame_edge = bit_end && slot == SLOT_W'(SLOT_BITS - 1);
  assign take = sample && slot != '0 && int'(slot) <= DATA_WIDTH;
  always_comb begin
    state_d = state_q;
    ws_d    = ws_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    left_d  = take && state_q == LEFT ? {left_q[DATA_WIDTH-2:0], sd_s} : left_q;
    right_d = take && state_q == RIGHT ? {right_q[DATA_WIDTH-2:0], sd_s} : right_q;
    if (state_q == IDLE && en) begin
      state_d = LEFT;
      busy_d  = 1'b1;
      ws_d    = 1'b0;
      left_d  = '0;
      right_d = '0;
    end else if (frame_edge && state_q == LEFT) begin
      state_d = RIGHT;
      ws_d    = 1'b1;
    end else if (frame_edge && state_q == RIGHT) begin
      dout_d  = {left_q, right_d};
      valid_d = 1'b1;
      ws_d    = 1'b0;
      state_d = en ? LEFT : IDLE;
      busy_d  = en;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ws_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      dout_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], sd};
      state_q <= state_d;
      ws_q    <= ws_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      left_q  <= left_d;
      right_q <= right_d;
      dout_q  <= dout_d;
    end
  end
  assign ws         = ws_q;
  assign busy       = busy_q;
  assign dout       = $signed(dout_q);
  assign dout_valid = valid_q;
endmodule

// File: tb/tb_i2s_receive.sv
// tb_i2s_receive: scoreboard bench with an I2S device model driving sd
module tb_i2s_receive;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, sd = 1'b0;
  logic sck, ws, dout_valid, busy;
  logic signed [47:0] dout;
  int total = 0, bad = 0, cyc = 0, wave_err = 0, wave_first = -1;
  logic [23:0] lw = '0, rw = '0;
  logic pad = 1'b0;
  typedef struct {
    logic [47:0] d;
    int          t;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  i2s_receive #(.DATA_WIDTH(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sd         (sd),
    .sck        (sck),
    .ws         (ws),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy)
  );
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got dout=%h at cycle %0d want no strobe", dout, cyc);
      end else begin
        e = exp_q.pop_front();
        check("dout", dout, e.d);
        check("valid_time", 48'(cyc), 48'(e.t));
      end
    end
  end
  // Device model: bench-owned frame timeline; sd is only correct around the sampling phase.
  initial begin
    int ph, bs, ch;
    logic was, b;
    ph = 0; bs = 0; ch = 0; was = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy !== 1'b1) begin
        was = 1'b0;
        sd  = 1'b0;
        if (sck !== 1'b0 || ws !== 1'b0) begin
          wave_err++;
          if (wave_first < 0) wave_first = cyc;
        end
      end else begin
        if (!was) begin
          ph = 0; bs = 0; ch = 0; was = 1'b1;
        end else begin
          ph++;
          if (ph == 32) begin
            ph = 0;
            bs++;
            if (bs == 32) begin
              bs = 0;
              ch ^= 1;
            end
          end
        end
        if (sck !== (ph >= 16) || ws !== ch[0]) begin
          wave_err++;
          if (wave_first < 0) wave_first = cyc;
        end
        b = pad;
        if (bs >= 1 && bs <= 24) b = ch[0] ? rw[24-bs] : lw[24-bs];
        sd = (ph >= 19 && ph <= 23) ? b : ~b;
      end
    end
  end
  task automatic start(input logic [23:0] l, input logic [23:0] r, input logic p, input logic hold, output int e);
    lw = l; rw = r; pad = p;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    e = cyc;
    if (!hold) en = 1'b0;
  endtask
  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dout_valid !== 1'b1 && n < 5000);
    if (dout_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got no strobe within %0d cycles want one", n);
    end
  endtask
  task automatic check_idle(input string name);
    check({name, "_sck"}, 48'(sck), 48'(0));
    check({name, "_ws"}, 48'(ws), 48'(0));
    check({name, "_busy"}, 48'(busy), 48'(0));
  endtask
  initial begin
    int e, n;
    repeat (4) @(negedge clk);
    check_idle("rst");
    check("rst_dout", dout, 48'(0));
    check("rst_valid", 48'(dout_valid), 48'(0));
    rst = 1'b0;
    start(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0, e);
    exp_q.push_back('{48'hA5A5A5_5A5A5A, e + 2048});
    n = 0;
    while (ws !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ws_rise", 48'(cyc), 48'(e + 1024));
    wait_valid();
    check("busy_drop1", 48'(busy), 48'(0));
    start(24'h800000, 24'h7FFFFF, 1'b1, 1'b0, e);
    exp_q.push_back('{48'h800000_7FFFFF, e + 2048});
    wait_valid();
    check("busy_drop2", 48'(busy), 48'(0));
    start(24'h000001, 24'h000002, 1'b0, 1'b1, e);
    exp_q.push_back('{48'h000001_000002, e + 2048});
    exp_q.push_back('{48'h000003_000004, e + 4096});
    exp_q.push_back('{48'h000005_000006, e + 6144});
    wait_valid();
    check("busy_hold", 48'(busy), 48'(1));
    lw = 24'h000003; rw = 24'h000004;
    wait_valid();
    lw = 24'h000005; rw = 24'h000006;
    en = 1'b0;
    wait_valid();
    check("busy_drop3", 48'(busy), 48'(0));
    start(24'h123456, 24'hFEDCBA, 1'b0, 1'b1, e);
    exp_q.push_back('{48'h123456_FEDCBA, e + 2048});
    while (cyc < e + 10 * 32 + 3) @(negedge clk);
    en = 1'b0;
    wait_valid();
    repeat (40) @(negedge clk);
    check_idle("en_drop");
    start(24'h0F0F0F, 24'hF0F0F0, 1'b0, 1'b0, e);
    while (cyc < e + 1024 + 12 * 32 + 20) @(negedge clk);
    check("pre_rst_sck", 48'(sck), 48'(1));
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_rst");
    check("mid_rst_dout", dout, 48'(0));
    check("mid_rst_valid", 48'(dout_valid), 48'(0));
    rst = 1'b0;
    start(24'hABCDEF, 24'h012345, 1'b0, 1'b0, e);
    exp_q.push_back('{48'hABCDEF_012345, e + 2048});
    wait_valid();
    repeat (10) @(negedge clk);
    check("queue_empty", 48'(exp_q.size()), 48'(0));
    check("wave_errors", 48'(wave_err), 48'(0));
    if (wave_err != 0) $display("first waveform deviation at cycle %0d", wave_first);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
